// File: rtl/uart_rx_word_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_word_pkg
//   Definitions shared by the receive path and the tx-side UART: the default
//   line rate, the clocks-per-bit helper and the receiver state encoding.
// -----------------------------------------------------------------------------
package uart_rx_word_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 100000000;
  localparam int unsigned BAUD_DEFAULT     = 921600;

  // Receiver FSM encoding; IDLE must stay 0 so a cleared register is idle.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Integer division on purpose: the residual baud error is absorbed by
  // sampling each bit near its centre.
  function automatic int unsigned uart_clks_per_bit(input int unsigned freq,
                                                    input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_word_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//   8N1 byte receiver: 2-FF synchroniser, bit-timing FSM, byte/frame strobes.
//
//   Ports
//     clk         in   system clock
//     res         in   synchronous reset, active-high
//     rx_in       in   serial line (asynchronous, idles high)
//     byte_data   out  last good byte, held between frames
//     byte_valid  out  1-cycle pulse per good byte
//     frame_err   out  1-cycle pulse when a stop bit is sampled low
//     rx_idle     out  FSM is in IDLE (used for the partial-word timeout)
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | line high, waiting for a falling edge
//   START      | half-bit wait, then confirm the start bit is still low
//   DATA       | sample 8 data bits at bit centres, LSB first
//   STOP       | sample the stop bit; high = good byte, low = frame error
//   WAIT_HIGH  | after a frame error, wait for the line to return high
// -----------------------------------------------------------------------------
module uart_rx_byte
  import uart_rx_word_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       res,
  input  logic       rx_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       rx_idle
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic          sync1_q, sync2_q;
  logic          rx_s;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_data_q;
  logic          byte_valid_q;
  logic          frame_err_q;

  logic cnt_done;
  logic load_half, load_full, sample_bit, stop_ok, stop_bad;

  assign rx_s     = sync2_q;
  assign cnt_done = (cnt_q == '0);

  // Synchroniser resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (res) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (res) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!rx_s) state_d = ST_START;
      ST_START:     if (cnt_done) state_d = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:      if (cnt_done && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:      if (cnt_done) state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rx_s) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_half  = 1'b0;
    load_full  = 1'b0;
    sample_bit = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    rx_idle    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rx_idle = 1'b1;
        if (!rx_s) load_half = 1'b1;
      end
      ST_START: if (cnt_done && !rx_s) load_full = 1'b1;
      ST_DATA: begin
        // The reload after bit 7 times the stop-bit sample.
        if (cnt_done) begin
          sample_bit = 1'b1;
          load_full  = 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_done) begin
          stop_ok  = rx_s;
          stop_bad = !rx_s;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      if (load_half)      cnt_q <= HALF_LOAD;
      else if (load_full) cnt_q <= FULL_LOAD;
      else if (!cnt_done) cnt_q <= cnt_q - CW'(1);

      if (state_q != ST_DATA) bit_idx_q <= '0;
      else if (sample_bit)    bit_idx_q <= bit_idx_q + 3'd1;

      if (sample_bit) shift_q <= {rx_s, shift_q[7:1]};

      byte_valid_q <= stop_ok;
      if (stop_ok) byte_data_q <= shift_q;
      frame_err_q <= stop_bad;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_rx_word.sv
// -----------------------------------------------------------------------------
// uart_rx_word
//   Receives an 8N1 byte stream and assembles WORD_BYTES bytes (little-endian)
//   into one word offered on a valid/taken handshake. Feeds the spoon_feed /
//   spoon_taken path so program and data can be streamed over the debug cable.
//
//   Ports
//     clk          in   system clock
//     res          in   synchronous reset, active-high
//     rx_in        in   serial line (asynchronous, idles high)
//     word_data    out  assembled word, first byte in bits [7:0]
//     word_valid   out  word_data holds an unconsumed word
//     word_taken   in   consumer accepts the word (only while word_valid=1)
//     byte_data    out  last received byte (debug)
//     byte_valid   out  1-cycle pulse per good byte
//     err_frame    out  sticky: a stop bit was sampled low
//     err_overrun  out  sticky: a word completed while the previous was held
//     err_clear    in   clears both sticky flags (a same-cycle set wins)
//
//   CLK_FREQ/BAUD must give at least 4 clocks per bit.
// -----------------------------------------------------------------------------
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEFAULT,
  parameter int unsigned BAUD         = BAUD_DEFAULT,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    rx_in,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_taken,
  output logic [7:0]              byte_data,
  output logic                    byte_valid,
  output logic                    err_frame,
  output logic                    err_overrun,
  input  logic                    err_clear
);

  localparam int unsigned CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned WW           = 8 * WORD_BYTES;
  localparam int unsigned IW           = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(WORD_BYTES - 1);
  localparam int unsigned TMO_CYC      = TIMEOUT_BITS * CLKS_PER_BIT;

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_ferr;
  logic          rx_idle;

  logic [IW-1:0] byte_idx_q;
  logic [WW-1:0] word_shift_q;
  logic [WW-1:0] word_data_q;
  logic          word_valid_q;
  logic          err_frame_q;
  logic          err_overrun_q;

  logic [WW-1:0] word_next;
  logic          word_done;
  logic          tmo_fire;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .res        (res),
    .rx_in      (rx_in),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_ferr),
    .rx_idle    (rx_idle)
  );

  // Partial word with the incoming byte dropped into its lane; on the last
  // byte this is the complete word.
  always_comb begin
    word_next = word_shift_q;
    word_next[int'(byte_idx_q) * 8 +: 8] = rx_byte;
  end

  assign word_done = rx_valid && (byte_idx_q == LAST_IDX);

  // Partial-word timeout: armed only while a word is part-built and the line
  // is idle; any reception disarms and reloads it.
  generate
    if (TIMEOUT_BITS > 0) begin : g_tmo
      localparam int unsigned TW = $clog2(TMO_CYC + 1);
      localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYC - 1);

      logic [TW-1:0] tmo_cnt_q;
      logic          tmo_armed;

      assign tmo_armed = rx_idle && (byte_idx_q != '0);

      always_ff @(posedge clk) begin
        if (res || !tmo_armed)    tmo_cnt_q <= TMO_LOAD;
        else if (tmo_cnt_q != '0) tmo_cnt_q <= tmo_cnt_q - TW'(1);
      end

      assign tmo_fire = tmo_armed && (tmo_cnt_q == '0);
    end else begin : g_no_tmo
      assign tmo_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (res) begin
      byte_idx_q    <= '0;
      word_shift_q  <= '0;
      word_data_q   <= '0;
      word_valid_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      if (rx_ferr || tmo_fire) begin
        byte_idx_q   <= '0;
        word_shift_q <= '0;
      end else if (rx_valid) begin
        if (word_done) begin
          byte_idx_q   <= '0;
          word_shift_q <= '0;
        end else begin
          byte_idx_q   <= byte_idx_q + IW'(1);
          word_shift_q <= word_next;
        end
      end

      // A take in the completion cycle frees the slot for the new word.
      if (word_done && (!word_valid_q || word_taken)) begin
        word_data_q  <= word_next;
        word_valid_q <= 1'b1;
      end else if (word_taken && word_valid_q) begin
        word_valid_q <= 1'b0;
      end

      if (word_done && word_valid_q && !word_taken) err_overrun_q <= 1'b1;
      else if (err_clear)                           err_overrun_q <= 1'b0;

      if (rx_ferr)        err_frame_q <= 1'b1;
      else if (err_clear) err_frame_q <= 1'b0;
    end
  end

  assign word_data   = word_data_q;
  assign word_valid  = word_valid_q;
  assign byte_data   = rx_byte;
  assign byte_valid  = rx_valid;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Receive-side counterpart of the debug UART transmitter.
- Deserialises a 921600-baud 8N1 line from the host, assembles 4 consecutive bytes (little-endian) into a 32-bit word, and presents it on a valid/taken handshake.
- Drives the top-level spoon_feed / spoon_taken path into memory_controller, so program and data words can be streamed in over the same cable used for tx_out.
- Flags framing errors and overruns.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 921600, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (108 at the defaults); must be >= 4.
- WORD_BYTES, 4, bytes per output word. Word width is 8*WORD_BYTES.
- TIMEOUT_BITS, 32, idle bit-times after which a partial word is discarded; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- res  in  1  synchronous reset, active-high
- rx_in  in  1  serial line, asynchronous to clk, idles high
- word_data  out  8*WORD_BYTES  assembled word; the first received byte is in bits [7:0]
- word_valid  out  1  word_data holds an unconsumed word
- word_taken  in  1  consumer accepts the word (effective only while word_valid=1)
- byte_data  out  8  last received byte (debug)
- byte_valid  out  1  1-cycle pulse per good byte
- err_frame  out  1  sticky; stop bit sampled low
- err_overrun  out  1  sticky; a word completed while word_valid=1 and word_taken=0
- err_clear  in  1  clears both sticky error flags

Behaviour:
- Interface decision: one clock (clk); reset res is synchronous and active-high.
- While res=1 on a clk edge:
  - All outputs are 0.
  - FSM goes to IDLE; byte index and counters are 0.
  - The synchroniser flops are set to 1.
  - Reset takes effect mid-frame; the partial byte or word is lost.
- Input path: 2-FF synchroniser on rx_in gives rx_s. All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START and load the bit counter with CLKS_PER_BIT/2-1.
  - START: at counter 0, sample rx_s.
    - rx_s=0: go to DATA with bit index 0 and counter CLKS_PER_BIT-1.
    - rx_s=1: treat as a glitch and return to IDLE; no error is flagged.
  - DATA: at each counter expiry, shift rx_s in LSB-first and reload the counter. After bit 7, go to STOP.
  - STOP: at counter expiry, sample rx_s.
    - rx_s=1: pulse byte_valid and update byte_data in that cycle, then go to IDLE.
    - rx_s=0: set err_frame, discard the byte and the partial word (byte index to 0), then go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. No break-length detection.
- Latency: byte_valid rises CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 2 cycles after the falling edge on rx_in (synchroniser included), ±1 cycle.
- Word assembly:
  - Each good byte k goes into bits [8k+7:8k] of an internal shift register.
  - On byte WORD_BYTES-1, the word is complete and byte index wraps to 0.
- Output register:
  - When a word completes and (word_valid=0 or word_taken=1): word_data loads and word_valid=1 from the next cycle.
  - When a word completes and word_valid=1 and word_taken=0: the new word is dropped, err_overrun is set, and word_data is unchanged.
  - When word_taken=1, word_valid=1, and no word completes: word_valid=0 next cycle.
  - The taken and new-word case in the same cycle leaves word_valid=1 with the new data.
- Timeout:
  - Applies when byte index != 0 and the FSM is in IDLE for TIMEOUT_BITS*CLKS_PER_BIT consecutive cycles.
  - Byte index resets to 0, the partial word is discarded, and no flag is raised.
  - The timeout counter resets on leaving IDLE.
- Error flags:
  - err_clear clears both flags.
  - When err_clear and a set event occur in the same cycle, set wins.
- Widths: the bit counter is $clog2(CLKS_PER_BIT) bits; the timeout counter is sized for TIMEOUT_BITS*CLKS_PER_BIT.

Decomposition:
- defines_uart.vh holds UART_CLKS_PER_BIT(freq, baud), the state encodings (localparams: 3-bit, IDLE=0), and the default BAUD, so it is shared with the tx-side uart.
- One sub-module, uart_rx_byte: synchroniser, FSM, and byte/frame error output.
- The top module adds word assembly, timeout, and handshake.

Test Plan:
- Bench parameters: CLK_FREQ=1600, BAUD=100, so CLKS_PER_BIT=16.
- Single word: send bytes 0xEF, 0xBE, 0xAD, 0xDE with word_taken=0 -> word_valid=1, word_data=0xDEADBEEF; four byte_valid pulses; err flags 0. Then pulse word_taken -> word_valid=0 the next cycle.
- Glitch: drive rx_in low for 4 cycles, then high -> no byte_valid and FSM back in IDLE; a following byte 0x55 is received correctly.
- Framing: send 0xA5 with the stop bit held low -> err_frame=1, no byte_valid. Then send a full word 0x04030201 -> word_data=0x04030201, with no stale byte from before the error.
- Overrun: send two words 0x11111111 and 0x22222222 with word_taken=0 -> err_overrun=1, word_data=0x11111111. Pulse err_clear -> err_overrun=0.
- Taken on completion: hold word_taken=1 in the completion cycle of the second word -> word_valid stays 1, word_data=0x22222222, err_overrun=0.
- Timeout and reset:
  - Send 2 bytes, then idle 32*16 cycles, then send 0x78, 0x56, 0x34, 0x12 -> word_data=0x12345678.
  - Assert res mid-byte -> all outputs 0 next cycle, and reception recovers on the next frame.
